// File: rtl/post_pkg.sv
// Shared types for the post clock/run controller: FSM encoding, STATUS codes
// and the prescaler tap clamp.
package post_pkg;

    // FSM state encoding; the values double as the STATUS output codes.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_STEP   = 2'd2,
        ST_HALTED = 2'd3
    } post_state_e;

    localparam int unsigned STATUS_W       = 2;
    localparam logic [1:0]  STATUS_IDLE    = 2'd0;
    localparam logic [1:0]  STATUS_RUN     = 2'd1;
    localparam logic [1:0]  STATUS_STEP    = 2'd2;
    localparam logic [1:0]  STATUS_HALTED  = 2'd3;

    localparam int unsigned CYC_W          = 16;

    // Selected prescaler tap, clamped to the top prescaler bit.
    function automatic int unsigned clamp_tap(input int unsigned base,
                                              input int unsigned sel,
                                              input int unsigned max_tap);
        int unsigned sum;
        sum = base + sel;
        return (sum > max_tap) ? max_tap : sum;
    endfunction

endpackage

// File: rtl/post_btn_cond.sv
// Push-button conditioner: 2-flop synchronizer, DEB_LEN-sample debouncer and
// a registered one-cycle pulse on each accepted 0->1 transition.
module post_btn_cond #(
    parameter int unsigned DEB_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    localparam int unsigned CNT_W   = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_LEN - 1);

    logic [1:0]       sync_q;
    logic             level_q;
    logic [CNT_W-1:0] cnt_q;
    logic             rise_q;

    // Two-stage synchronizer for the raw asynchronous button.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], btn};
        end
    end

    // Accept a new level only after DEB_LEN consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
            rise_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            if (sync_q[1] != level_q) begin
                if (cnt_q == CNT_LAST) begin
                    level_q <= sync_q[1];
                    cnt_q   <= '0;
                    rise_q  <= sync_q[1];
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else begin
                cnt_q <= '0;
            end
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/post_clk_run_ctrl.sv
// CPU clock-enable and run/step controller. A free-running prescaler with a
// runtime-selectable tap produces the tick; a four-state FSM gates it onto
// CPU_CE from conditioned RUN/STEP buttons. Optional CYC_CNT output is
// enabled by defining POST_CYCLE_CNT_EN.
module post_clk_run_ctrl
    import post_pkg::*;
#(
    parameter int unsigned DIV_W    = 26,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned BASE_TAP = 10,
    parameter int unsigned DEB_LEN  = 3
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [SEL_W-1:0]    SPEED_SEL,
    input  logic                MODE,
    input  logic                RUN,
    input  logic                STEP,
    input  logic                HALT_IN,
    output logic                CPU_CE,
    output logic                CPU_RUN,
`ifdef POST_CYCLE_CNT_EN
    output logic [STATUS_W-1:0] STATUS,
    output logic [CYC_W-1:0]    CYC_CNT
`else
    output logic [STATUS_W-1:0] STATUS
`endif
);

    localparam int unsigned MAX_TAP = DIV_W - 1;

    logic [DIV_W-1:0] presc_q;
    logic [SEL_W-1:0] sel_q;
    logic [DIV_W-1:0] tap_mask_c;
    logic             tick_c;
    int unsigned      tap_c;

    logic             run_rise;
    logic             step_rise;

    post_state_e      state_q;
    logic             cpu_ce_q;
    logic             cpu_run_q;

    // Free-running prescaler, wraps naturally.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_q + DIV_W'(1);
        end
    end

    // Mask of prescaler bits [tap:0]; tick when all of them are ones.
    always_comb begin
        tap_c      = clamp_tap(BASE_TAP, 32'(sel_q), MAX_TAP);
        tap_mask_c = '0;
        for (int unsigned i = 0; i < DIV_W; i++) begin
            tap_mask_c[i] = (i <= tap_c);
        end
        tick_c = &(presc_q | ~tap_mask_c);
    end

    // Speed selector only changes at a period boundary.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sel_q <= '0;
        end else if (tick_c) begin
            sel_q <= SPEED_SEL;
        end
    end

    post_btn_cond #(.DEB_LEN(DEB_LEN)) u_run_btn (
        .clk   (CLK),
        .rst_n (RST),
        .btn   (RUN),
        .rise  (run_rise)
    );

    post_btn_cond #(.DEB_LEN(DEB_LEN)) u_step_btn (
        .clk   (CLK),
        .rst_n (RST),
        .btn   (STEP),
        .rise  (step_rise)
    );

    // Run/step FSM with registered CPU_CE and CPU_RUN.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= ST_IDLE;
            cpu_ce_q  <= 1'b0;
            cpu_run_q <= 1'b0;
        end else begin
            cpu_ce_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (MODE && run_rise) begin
                        state_q   <= ST_RUN;
                        cpu_run_q <= 1'b1;
                    end else if (MODE && step_rise) begin
                        state_q   <= ST_STEP;
                        cpu_run_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (HALT_IN) begin
                        state_q   <= ST_HALTED;
                        cpu_run_q <= 1'b0;
                    end else if (!MODE) begin
                        state_q   <= ST_IDLE;
                        cpu_run_q <= 1'b0;
                    end else if (run_rise) begin
                        state_q   <= ST_IDLE;
                        cpu_run_q <= 1'b0;
                        cpu_ce_q  <= tick_c;
                    end else begin
                        cpu_ce_q  <= tick_c;
                    end
                end
                ST_STEP: begin
                    if (!MODE) begin
                        state_q   <= ST_IDLE;
                        cpu_run_q <= 1'b0;
                    end else if (tick_c) begin
                        cpu_ce_q  <= 1'b1;
                        cpu_run_q <= 1'b0;
                        state_q   <= HALT_IN ? ST_HALTED : ST_IDLE;
                    end
                end
                ST_HALTED: begin
                    if (!MODE || run_rise) begin
                        state_q   <= ST_IDLE;
                        cpu_run_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    cpu_run_q <= 1'b0;
                end
            endcase
        end
    end

    assign CPU_CE  = cpu_ce_q;
    assign CPU_RUN = cpu_run_q;
    assign STATUS  = state_q;

`ifdef POST_CYCLE_CNT_EN
    logic [CYC_W-1:0] cyc_q;

    // Saturating count of CPU_CE pulses, restarted whenever execution begins.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cyc_q <= '0;
        end else if (state_q == ST_IDLE && MODE && (run_rise || step_rise)) begin
            cyc_q <= '0;
        end else if (cpu_ce_q && (cyc_q != {CYC_W{1'b1}})) begin
            cyc_q <= cyc_q + CYC_W'(1);
        end
    end

    assign CYC_CNT = cyc_q;
`endif

endmodule

// File: tb/tb_post_clk_run_ctrl.sv
// Self-checking bench for post_clk_run_ctrl (DIV_W=8, BASE_TAP=2, DEB_LEN=3).
module tb_post_clk_run_ctrl;

    localparam int unsigned DIV_W    = 8;
    localparam int unsigned SEL_W    = 4;
    localparam int unsigned BASE_TAP = 2;
    localparam int unsigned DEB_LEN  = 3;

    logic             CLK = 1'b0;
    logic             RST;
    logic [SEL_W-1:0] SPEED_SEL;
    logic             MODE;
    logic             RUN;
    logic             STEP;
    logic             HALT_IN;
    logic             CPU_CE;
    logic             CPU_RUN;
    logic [1:0]       STATUS;
`ifdef POST_CYCLE_CNT_EN
    logic [15:0]      CYC_CNT;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int ce_seen = 0;

    post_clk_run_ctrl #(
        .DIV_W    (DIV_W),
        .SEL_W    (SEL_W),
        .BASE_TAP (BASE_TAP),
        .DEB_LEN  (DEB_LEN)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .SPEED_SEL (SPEED_SEL),
        .MODE      (MODE),
        .RUN       (RUN),
        .STEP      (STEP),
        .HALT_IN   (HALT_IN),
        .CPU_CE    (CPU_CE),
        .CPU_RUN   (CPU_RUN),
`ifdef POST_CYCLE_CNT_EN
        .STATUS    (STATUS),
        .CYC_CNT   (CYC_CNT)
`else
        .STATUS    (STATUS)
`endif
    );

    always #5 CLK = ~CLK;

    // Count CPU_CE pulses as they complete.
    always @(posedge CLK) begin
        if (CPU_CE === 1'b1) ce_seen <= ce_seen + 1;
    end

    typedef struct {
        string      name;
        int         act;      // 0 none, 1 RUN press, 2 STEP press
        logic       mode;
        logic       halt;
        logic [1:0] exp_status;
        logic       exp_run;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic press(input int which);
        if (which == 1) RUN = 1'b1; else STEP = 1'b1;
        cycles(DEB_LEN + 4);
        RUN  = 1'b0;
        STEP = 1'b0;
        cycles(12);
    endtask

    // Negedges until CPU_CE is seen high, bounded by limit.
    task automatic wait_ce(input int limit, output int n);
        n = 0;
        for (int k = 0; k < limit; k++) begin
            @(negedge CLK);
            n++;
            if (CPU_CE === 1'b1) return;
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_ce timeout: got no CPU_CE expected within %0d cycles", limit);
    endtask

    initial begin
        int n;
        int c0;

        vecs[0]  = '{"step_from_idle",  2, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{"run_start",       1, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[2]  = '{"run_pause",       1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{"run_again",       1, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[4]  = '{"halt_in_run",     0, 1'b1, 1'b1, 2'd3, 1'b0};
        vecs[5]  = '{"step_in_halted",  2, 1'b1, 1'b1, 2'd3, 1'b0};
        vecs[6]  = '{"run_from_halted", 1, 1'b1, 1'b0, 2'd0, 1'b0};
        vecs[7]  = '{"run_mode0",       1, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[8]  = '{"step_mode0",      2, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[9]  = '{"run_mode1",       1, 1'b1, 1'b0, 2'd1, 1'b1};
        vecs[10] = '{"mode0_in_run",    0, 1'b0, 1'b0, 2'd0, 1'b0};
        vecs[11] = '{"step_again",      2, 1'b1, 1'b0, 2'd0, 1'b0};

        RST = 1'b0; SPEED_SEL = '0; MODE = 1'b0; RUN = 1'b0; STEP = 1'b0; HALT_IN = 1'b0;

        // Reset values
        cycles(3);
        check("rst_ce",     int'(CPU_CE),  0);
        check("rst_cpurun", int'(CPU_RUN), 0);
        check("rst_status", int'(STATUS),  0);
        RST = 1'b1;
        cycles(2);
        check("post_rst_status", int'(STATUS), 0);

        // RUN at base speed: period 8
        MODE = 1'b1;
        press(1);
        check("run_status", int'(STATUS), 1);
        check("run_cpurun", int'(CPU_RUN), 1);
        wait_ce(20, n);
        cycles(1);
        check("ce_one_cycle", int'(CPU_CE), 0);
        wait_ce(20, n);
        check("period8_a", n, 7);
        wait_ce(20, n);
        check("period8_b", n, 8);

        // Speed change mid-period: current period completes first
        cycles(3);
        SPEED_SEL = 4'd3;
        wait_ce(20, n);
        check("sel3_finish8", n + 3, 8);
        wait_ce(80, n);
        check("sel3_first_bounded", int'(n <= 64 && (n % 8) == 0), 1);
        wait_ce(80, n);
        check("period64_a", n, 64);
        SPEED_SEL = 4'd15;
        wait_ce(80, n);
        check("period64_b", n, 64);
        wait_ce(300, n);
        check("sel15_first_bounded", int'(n <= 256), 1);
        wait_ce(300, n);
        check("period256", n, 256);
        SPEED_SEL = 4'd0;
        wait_ce(300, n);
        wait_ce(20, n);
        check("back_to_8", n, 8);
        press(1);
        check("pause_status", int'(STATUS), 0);

        // Two single steps
        c0 = ce_seen;
        press(2);
        check("step1_status", int'(STATUS), 0);
        press(2);
        check("step2_status", int'(STATUS), 0);
        check("step_ce_count", ce_seen - c0, 2);

        // Table-driven sequence of button/mode/halt events
        for (int i = 0; i < 12; i++) begin
            MODE    = vecs[i].mode;
            HALT_IN = vecs[i].halt;
            cycles(2);
            if (vecs[i].act != 0) press(vecs[i].act);
            cycles(2);
            check({vecs[i].name, "_status"}, int'(STATUS),  int'(vecs[i].exp_status));
            check({vecs[i].name, "_cpurun"}, int'(CPU_RUN), int'(vecs[i].exp_run));
        end

        // Halt: no CE, STEP ignored, RUN returns to IDLE
        MODE = 1'b1; HALT_IN = 1'b0;
        press(1);
        check("halt_pre_status", int'(STATUS), 1);
        HALT_IN = 1'b1;
        cycles(2);
        check("halted_status", int'(STATUS), 3);
        c0 = ce_seen;
        cycles(40);
        check("halted_no_ce", ce_seen - c0, 0);
        press(2);
        check("halted_step_ignored", int'(STATUS), 3);
        check("halted_step_no_ce", ce_seen - c0, 0);
        HALT_IN = 1'b0;
        press(1);
        check("halted_run_to_idle", int'(STATUS), 0);

        // Bounce of 1 and 2 cycles is rejected
        RUN = 1'b1; cycles(1); RUN = 1'b0; cycles(5);
        RUN = 1'b1; cycles(2); RUN = 1'b0; cycles(10);
        check("bounce_no_edge", int'(STATUS), 0);
        RUN = 1'b1; cycles(DEB_LEN + 2); RUN = 1'b0; cycles(10);
        check("held_one_edge", int'(STATUS), 1);
        MODE = 1'b0;
        cycles(1);
        check("mode0_next_cycle", int'(STATUS), 0);
        check("mode0_ce_low", int'(CPU_CE), 0);
        cycles(2);

`ifdef POST_CYCLE_CNT_EN
        // Cycle counter: ten pulses then cleared by reset
        MODE = 1'b1;
        c0 = ce_seen;
        press(1);
        for (int k = 0; k < 400; k++) begin
            if (ce_seen - c0 >= 10) break;
            @(negedge CLK);
        end
        check("cyc_reached_10", ce_seen - c0, 10);
        check("cyc_cnt_10", int'(CYC_CNT), 10);
        RST = 1'b0;
        #1;
        check("cyc_cnt_rst", int'(CYC_CNT), 0);
        cycles(2);
        RST = 1'b1;
        cycles(2);
        MODE = 1'b0;
        cycles(2);
`endif

        // Reset asserted mid-RUN while CPU_CE is high
        MODE = 1'b1;
        press(1);
        check("g_run_status", int'(STATUS), 1);
        wait_ce(20, n);
        #1 RST = 1'b0;
        #1;
        check("rst_mid_ce",     int'(CPU_CE),  0);
        check("rst_mid_cpurun", int'(CPU_RUN), 0);
        check("rst_mid_status", int'(STATUS),  0);
        cycles(3);
        RST = 1'b1;
        c0 = ce_seen;
        cycles(30);
        check("after_rst_no_ce",  ce_seen - c0, 0);
        check("after_rst_status", int'(STATUS), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/post_clk_run_ctrl.md
POST_CLK_RUN_CTRL -- requirements
Module: post_clk_run_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 26, width of the free-running prescaler.
REQ-002 SHALL have parameter SEL_W, default 4, width of the runtime speed selector.
REQ-003 SHALL have parameter BASE_TAP, default 10, prescaler bit used when SPEED_SEL=0.
REQ-004 SHALL have parameter DEB_LEN, default 3, consecutive equal samples needed to accept a button level.
REQ-005 SHALL have port CLK, input, 1, the single system clock; all logic is in this domain.
REQ-006 SHALL have port RST, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port SPEED_SEL, input, SEL_W, runtime tick-rate select.
REQ-008 SHALL have port MODE, input, 1; 1 = execute, 0 = program (SPI owns memory).
REQ-009 SHALL have ports RUN and STEP, input, 1 each, raw asynchronous push-buttons.
REQ-010 SHALL have port HALT_IN, input, 1, CPU halt indication.
REQ-011 SHALL have port CPU_CE, output, 1, one-CLK-cycle CPU clock enable.
REQ-012 SHALL have port CPU_RUN, output, 1, high while the FSM is in RUN or STEP.
REQ-013 SHALL have port STATUS, output, 2, FSM state code (IDLE=0, RUN=1, STEP=2, HALTED=3).

Function
REQ-014 SHALL increment the DIV_W-bit prescaler every CLK, wrapping from all-ones to zero.
REQ-015 SHALL use tap k = min(BASE_TAP + sel_q, DIV_W-1), where sel_q is the registered selector.
REQ-016 SHALL assert tick for one cycle when prescaler[k:0] is all ones, giving a period of 2^(k+1) CLK.
REQ-017 SHALL load sel_q from SPEED_SEL only on a tick cycle, so a speed change never produces a short period.
REQ-018 SHALL pass RUN and STEP through 2-flop synchronizers and then a DEB_LEN-sample debouncer.
REQ-019 SHALL produce a one-cycle edge pulse on each 0->1 transition of a debounced button.
REQ-020 SHALL implement the IDLE state: CPU_CE=0; a RUN edge with MODE=1 goes to RUN; a STEP edge with MODE=1 goes to STEP.
REQ-021 SHALL implement the RUN state: CPU_CE=tick; HALT_IN=1 goes to HALTED; a RUN edge goes to IDLE (pause).
REQ-022 SHALL implement the STEP state: wait for the next tick, assert CPU_CE on that tick only, then go to HALTED if HALT_IN=1, otherwise to IDLE.
REQ-023 SHALL implement the HALTED state: CPU_CE=0; a RUN edge goes to IDLE; STEP edges are ignored.
REQ-024 SHALL force MODE=0 in any state to IDLE on the next cycle, with CPU_CE=0 on that same cycle.
REQ-025 SHALL give priority HALT_IN > MODE=0 > RUN edge > STEP edge when events coincide.
REQ-026 SHALL drive CPU_CE, CPU_RUN and STATUS from registers, so CPU_CE appears 1 cycle after the tick condition.

Reset
REQ-027 SHALL, while RST=0, clear the prescaler, sel_q, synchronizers, debouncers and edge pulses, and force the FSM to IDLE.
REQ-028 SHALL hold CPU_CE=0, CPU_RUN=0 and STATUS=0 during and after reset.
REQ-029 SHALL, when reset is asserted mid-RUN, drop CPU_CE within the reset assertion and emit no partial tick.

Configuration
REQ-030 SHALL, with POST_CYCLE_CNT_EN defined, add output CYC_CNT[15:0], which counts CPU_CE pulses, saturates at 16'hFFFF, and is cleared by reset and on every IDLE->RUN or IDLE->STEP transition.
REQ-031 SHALL, without POST_CYCLE_CNT_EN, have no CYC_CNT port or counter logic.

Structure
REQ-032 SHALL place the FSM state encoding and the STATUS codes in the shared package post_pkg.
REQ-033 SHALL implement the synchronizer + debouncer + edge detector as sub-module post_btn_cond, instanced twice (RUN and STEP).

Verification
REQ-034 SHALL cover: DIV_W=8, BASE_TAP=2, SPEED_SEL=0, RUN pressed, MODE=1 -> CPU_CE every 8 CLK, STATUS=1.
REQ-035 SHALL cover: SPEED_SEL changed 0->3 mid-period -> the current 8-cycle period completes, then the period is 64 CLK; SPEED_SEL=15 clamps to tap 7 (period 256).
REQ-036 SHALL cover: 2 STEP presses from IDLE -> exactly 2 CPU_CE pulses, STATUS returns to 0 after each.
REQ-037 SHALL cover: HALT_IN=1 while in RUN -> STATUS=3 and no further CPU_CE; STEP ignored; RUN edge -> STATUS=0.
REQ-038 SHALL cover: button bounce of 1-2 cycles -> no edge; a level held for DEB_LEN+2 cycles -> exactly one edge; MODE=0 in RUN -> IDLE next cycle.
REQ-039 SHALL cover: RST=0 mid-RUN -> outputs zero immediately; with POST_CYCLE_CNT_EN, 10 ticks then RST -> CYC_CNT 10 then 0.
